// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dds_pkg
// Description : Constants, typedefs and helpers shared by the phase
//               accumulator and the sine/cosine DDS lookup stage.
// Revision    : 1.0 - initial release
// ============================================================================
package dds_pkg;

   // Dither LFSR: 16-bit Galois form of x^16+x^14+x^13+x^11+1 (right shift)
   localparam int          LFSR_W            = 16;
   localparam logic [15:0] LFSR_POLY         = 16'hB400;
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

   // Phase word shared with the DDS lookup
   localparam int DDS_PHASE_DW = 16;
   typedef logic [DDS_PHASE_DW-1:0] phase_t;

   // Quadrant boundaries used by the DDS quarter-wave table
   localparam phase_t PHASE_QUARTER = phase_t'(2 ** (DDS_PHASE_DW - 2));
   localparam phase_t PHASE_HALF    = phase_t'(2 ** (DDS_PHASE_DW - 1));

   // One Galois step: shift right, fold the polynomial in when a 1 falls out
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      logic [15:0] n;
      n = s >> 1;
      if (s[0]) begin
         n = n ^ LFSR_POLY;
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_dither.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_dither
// Description : Free-running 16-bit Galois LFSR that advances only when
//               stepped; supplies pseudo-random dither bits.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_dither
   import dds_pkg::*;
#(
   parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        step,
   output logic [15:0] state
);

   logic [15:0] state_q;
   logic [15:0] state_d;

   // Next state: advance one polynomial step when requested, else hold
   always_comb begin
      state_d = state_q;
      if (step) begin
         state_d = lfsr_next(state_q);
      end
   end

   // State register; a non-zero seed keeps the sequence off the all-zero lock-up
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/phase_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : phase_accumulator
// Description : NCO phase generator feeding the DDS lookup. Accumulates the
//               frequency tuning word, then truncates, offsets and optionally
//               dithers the phase. Two-stage pipeline with wrap indication.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_accumulator
   import dds_pkg::*;
#(
   parameter int          ACC_DW     = 32,
   parameter int          PHASE_DW   = 16,
   parameter int          USE_DITHER = 0,
   parameter int          DITHER_DW  = 4,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ACC_DW-1:0]   s_axis_freq_tdata,
   input  logic                s_axis_freq_tvalid,
   input  logic [PHASE_DW-1:0] s_axis_offset_tdata,
   input  logic                s_axis_offset_tvalid,
   input  logic                sync_in,
   input  logic                enable,
   output logic [PHASE_DW-1:0] m_axis_phase_tdata,
   output logic                m_axis_phase_tvalid,
   output logic                wrap
);

   localparam int TRUNC_SH = ACC_DW - PHASE_DW;

   // Parameter sanity: a bad configuration must not elaborate
   if (PHASE_DW > ACC_DW) begin : g_chk_phase_dw
      $fatal(1, "phase_accumulator: PHASE_DW must not exceed ACC_DW");
   end
   if ((USE_DITHER != 0) && (DITHER_DW > ACC_DW - PHASE_DW)) begin : g_chk_dither_dw
      $fatal(1, "phase_accumulator: DITHER_DW exceeds the truncated bits");
   end
   if (LFSR_SEED == 16'h0000) begin : g_chk_seed
      $fatal(1, "phase_accumulator: LFSR_SEED must be non-zero");
   end

   // Configuration registers
   logic [ACC_DW-1:0]   ftw_q,    ftw_d;
   logic [PHASE_DW-1:0] offset_q, offset_d;
   // Stage 1: accumulator, sample-valid and carry (wrap) flags
   logic [ACC_DW-1:0]   acc_q,    acc_d;
   logic                v1_q,     v1_d;
   logic                w1_q,     w1_d;
   // Stage 2: registered outputs
   logic [PHASE_DW-1:0] phase_q,  phase_d;
   logic                tvalid_q, tvalid_d;
   logic                wrap_q,   wrap_d;

   logic [ACC_DW-1:0]   dither_w;

   // Dither sits entirely below the truncation point so it moves the output
   // by at most one LSB
   if (USE_DITHER != 0) begin : g_dither
      localparam int DITHER_SH = ACC_DW - PHASE_DW - DITHER_DW;
      logic [15:0] lfsr_state;
      logic        unused_lfsr;

      lfsr_dither #(
         .SEED (LFSR_SEED)
      ) u_lfsr (
         .clk     (clk),
         .reset_n (reset_n),
         .step    (enable & ~sync_in),
         .state   (lfsr_state)
      );

      assign dither_w    = ACC_DW'(lfsr_state[DITHER_DW-1:0]) << DITHER_SH;
      assign unused_lfsr = ^lfsr_state;
   end else begin : g_no_dither
      assign dither_w = '0;
   end

   // Config loads and stage-1 accumulate; sync clears even without enable
   always_comb begin
      ftw_d    = s_axis_freq_tvalid   ? s_axis_freq_tdata   : ftw_q;
      offset_d = s_axis_offset_tvalid ? s_axis_offset_tdata : offset_q;
      acc_d    = acc_q;
      w1_d     = 1'b0;
      if (sync_in) begin
         acc_d = '0;
         w1_d  = 1'b0;
      end else if (enable) begin
         {w1_d, acc_d} = {1'b0, acc_q} + {1'b0, ftw_q};
      end
      v1_d = enable | sync_in;
   end

   // Stage 2: truncate the (dithered) accumulator and add the phase offset;
   // data holds across gaps so the DDS sees a stable phase
   always_comb begin
      phase_d = phase_q;
      if (v1_q) begin
         phase_d = PHASE_DW'((acc_q + dither_w) >> TRUNC_SH) + offset_q;
      end
      tvalid_d = v1_q;
      wrap_d   = w1_q & v1_q;
   end

   // All state registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ftw_q    <= '0;
         offset_q <= '0;
         acc_q    <= '0;
         v1_q     <= 1'b0;
         w1_q     <= 1'b0;
         phase_q  <= '0;
         tvalid_q <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         ftw_q    <= ftw_d;
         offset_q <= offset_d;
         acc_q    <= acc_d;
         v1_q     <= v1_d;
         w1_q     <= w1_d;
         phase_q  <= phase_d;
         tvalid_q <= tvalid_d;
         wrap_q   <= wrap_d;
      end
   end

   assign m_axis_phase_tdata  = phase_q;
   assign m_axis_phase_tvalid = tvalid_q;
   assign wrap                = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_phase_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_accumulator
// Description : Self-checking bench for phase_accumulator: directed vector
//               table, hand-written corner sequences, randomized stimulus
//               against an arithmetic reference model, and a dithered run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_accumulator;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] freq_data = '0;
   logic        freq_valid = 1'b0;
   logic [15:0] off_data = '0;
   logic        off_valid = 1'b0;
   logic        sync_in = 1'b0;
   logic        enable = 1'b0;

   logic [15:0] phase;
   logic        tvalid;
   logic        wrap;
   logic [15:0] phase_d;
   logic        tvalid_d;
   logic        wrap_d;

   int n_pass  = 0;
   int n_total = 0;

   // reference model state
   logic [31:0] m_acc, m_ftw;
   logic [15:0] m_off;
   logic        pend_valid, pend_wrap;
   logic        e_valid, e_wrap;
   logic [15:0] e_phase;

   always #5 clk = ~clk;

   phase_accumulator #(
      .ACC_DW(32), .PHASE_DW(16), .USE_DITHER(0), .DITHER_DW(4), .LFSR_SEED(16'hACE1)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .s_axis_freq_tdata(freq_data), .s_axis_freq_tvalid(freq_valid),
      .s_axis_offset_tdata(off_data), .s_axis_offset_tvalid(off_valid),
      .sync_in(sync_in), .enable(enable),
      .m_axis_phase_tdata(phase), .m_axis_phase_tvalid(tvalid), .wrap(wrap)
   );

   phase_accumulator #(
      .ACC_DW(32), .PHASE_DW(16), .USE_DITHER(1), .DITHER_DW(4), .LFSR_SEED(16'hACE1)
   ) dut_d (
      .clk(clk), .reset_n(reset_n),
      .s_axis_freq_tdata(freq_data), .s_axis_freq_tvalid(freq_valid),
      .s_axis_offset_tdata(off_data), .s_axis_offset_tvalid(off_valid),
      .sync_in(sync_in), .enable(enable),
      .m_axis_phase_tdata(phase_d), .m_axis_phase_tvalid(tvalid_d), .wrap(wrap_d)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // Behavioural model: a sample is the top 16 bits of the running phase sum
   // (mod 2**32) plus the current offset, appearing one edge after the step.
   task automatic model_edge(input logic r, fv, input logic [31:0] fd,
                             input logic ov, input logic [15:0] od, input logic sy, en);
      longint unsigned sum;
      if (!r) begin
         m_acc = 0; m_ftw = 0; m_off = 0; pend_valid = 0; pend_wrap = 0;
         e_valid = 0; e_wrap = 0; e_phase = 0;
         return;
      end
      e_valid = pend_valid;
      e_wrap  = pend_valid & pend_wrap;
      if (pend_valid) e_phase = 16'((m_acc >> 16) + 32'(m_off));
      pend_valid = sy | en;
      pend_wrap  = 0;
      if (sy) m_acc = 0;
      else if (en) begin
         sum = longint'(m_acc) + longint'(m_ftw);
         pend_wrap = (sum >= 64'h1_0000_0000);
         m_acc = 32'(sum);
      end
      if (fv) m_ftw = fd;
      if (ov) m_off = od;
   endtask

   task automatic cycle(input logic r, fv, input logic [31:0] fd,
                        input logic ov, input logic [15:0] od, input logic sy, en);
      reset_n = r; freq_valid = fv; freq_data = fd;
      off_valid = ov; off_data = od; sync_in = sy; enable = en;
      @(posedge clk);
      model_edge(r, fv, fd, ov, od, sy, en);
      #1;
      chk("model_valid", 32'(tvalid), 32'(e_valid));
      chk("model_phase", 32'(phase), 32'(e_phase));
      chk("model_wrap", 32'(wrap), 32'(e_wrap));
   endtask

   typedef struct {
      logic        r, fv;
      logic [31:0] fd;
      logic        ov;
      logic [15:0] od;
      logic        sy, en;
      logic        ev;
      logic [15:0] ep;
      logic        ew;
   } vec_t;

   vec_t tbl[16];
   logic [31:0] rfd;
   int          sidx, wraps, nsamp, tot, dbad, dact, lzero;
   logic [15:0] prev, diff;
   logic        have_prev;

   initial begin
      //            r  fv fd            ov od       sy en   ev ep        ew
      tbl[0]  = '{0, 0, 32'h0,        0, 16'h0,    0, 0,   0, 16'h0000, 0};
      tbl[1]  = '{1, 1, 32'h0100_0000, 0, 16'h0,   0, 1,   0, 16'h0000, 0};
      tbl[2]  = '{1, 0, 32'h0,        0, 16'h0,    0, 1,   1, 16'h0000, 0};
      tbl[3]  = '{1, 0, 32'h0,        0, 16'h0,    0, 1,   1, 16'h0100, 0};
      tbl[4]  = '{1, 0, 32'h0,        0, 16'h0,    0, 0,   1, 16'h0200, 0};
      tbl[5]  = '{1, 0, 32'h0,        0, 16'h0,    0, 0,   0, 16'h0200, 0};
      tbl[6]  = '{1, 0, 32'h0,        1, 16'h4000, 0, 1,   0, 16'h0200, 0};
      tbl[7]  = '{1, 0, 32'h0,        0, 16'h0,    0, 1,   1, 16'h4300, 0};
      tbl[8]  = '{1, 0, 32'h0,        0, 16'h0,    1, 1,   1, 16'h4400, 0};
      tbl[9]  = '{1, 1, 32'h8000_0000, 0, 16'h0,   0, 0,   1, 16'h4000, 0};
      tbl[10] = '{1, 0, 32'h0,        0, 16'h0,    0, 1,   0, 16'h4000, 0};
      tbl[11] = '{1, 0, 32'h0,        0, 16'h0,    0, 1,   1, 16'hC000, 0};
      tbl[12] = '{1, 0, 32'h0,        0, 16'h0,    0, 1,   1, 16'h4000, 1};
      tbl[13] = '{0, 0, 32'h0,        0, 16'h0,    0, 1,   0, 16'h0000, 0};
      tbl[14] = '{1, 0, 32'h0,        0, 16'h0,    0, 1,   0, 16'h0000, 0};
      tbl[15] = '{1, 0, 32'h0,        0, 16'h0,    0, 1,   1, 16'h0000, 0};

      // ---- directed table ----
      for (int i = 0; i < 16; i++) begin
         cycle(tbl[i].r, tbl[i].fv, tbl[i].fd, tbl[i].ov, tbl[i].od, tbl[i].sy, tbl[i].en);
         chk($sformatf("tbl%0d_valid", i), 32'(tvalid), 32'(tbl[i].ev));
         chk($sformatf("tbl%0d_phase", i), 32'(phase), 32'(tbl[i].ep));
         chk($sformatf("tbl%0d_wrap", i), 32'(wrap), 32'(tbl[i].ew));
      end

      // ---- wrap on the 257th sample and every 256 thereafter ----
      cycle(0, 0, 0, 0, 0, 0, 0);
      cycle(1, 1, 32'h0100_0000, 0, 0, 0, 1);
      sidx = 0; wraps = 0;
      for (int i = 0; i < 600; i++) begin
         cycle(1, 0, 0, 0, 0, 0, 1);
         if (tvalid) begin
            if (wrap) wraps++;
            if (sidx == 256) begin
               chk("wrap_257th", 32'(wrap), 32'd1);
               chk("wrap_257th_phase", 32'(phase), 32'h0);
            end
            sidx++;
         end
      end
      chk("wrap_count", 32'(wraps), 32'd2);

      // ---- phase-continuous FTW change, then sync ----
      cycle(0, 0, 0, 0, 0, 0, 0);
      cycle(1, 1, 32'h0100_0000, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0, 0, 1);
      cycle(1, 1, 32'h0200_0000, 0, 0, 0, 1);
      cycle(1, 0, 0, 0, 0, 0, 1);
      chk("ftw_change_0500", 32'(phase), 32'h0500);
      cycle(1, 0, 0, 0, 0, 0, 1);
      chk("ftw_change_0700", 32'(phase), 32'h0700);
      cycle(1, 0, 0, 0, 0, 0, 1);
      chk("ftw_change_0900", 32'(phase), 32'h0900);
      cycle(1, 0, 0, 0, 0, 1, 1);
      cycle(1, 0, 0, 0, 0, 0, 1);
      chk("sync_restart", 32'(phase), 32'h0000);

      // ---- randomized stimulus against the model ----
      for (int i = 0; i < 2000; i++) begin
         case ($urandom_range(0, 3))
            0:       rfd = 32'h0;
            1:       rfd = 32'h8000_0000;
            default: rfd = $urandom();
         endcase
         cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 19) == 0), rfd,
               ($urandom_range(0, 29) == 0), 16'($urandom()),
               ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0));
      end

      // ---- dithered run: FTW = 1.5 LSB per sample ----
      cycle(0, 0, 0, 0, 0, 0, 0);
      chk("lfsr_seed", 32'(dut_d.g_dither.u_lfsr.state), 32'hACE1);
      cycle(1, 1, 32'h0001_8000, 0, 0, 0, 1);
      nsamp = 0; tot = 0; dbad = 0; dact = 0; lzero = 0; have_prev = 0; prev = 0;
      for (int i = 0; i < 65536; i++) begin
         cycle(1, 0, 0, 0, 0, 0, 1);
         if (dut_d.g_dither.u_lfsr.state == 16'h0) lzero++;
         if (tvalid_d) begin
            diff = phase_d - phase;
            if (diff > 16'd1) dbad++;
            if (diff != 16'd0) dact++;
            if (have_prev) tot += int'(16'(phase_d - prev));
            prev = phase_d; have_prev = 1; nsamp++;
         end
      end
      chk("dither_within_1lsb", 32'(dbad), 32'd0);
      chk("dither_active", 32'(dact > 0), 32'd1);
      chk("dither_mean_1p5", 32'((2 * tot >= 3 * (nsamp - 1) - 3) && (2 * tot <= 3 * (nsamp - 1) + 3)), 32'd1);
      chk("lfsr_never_zero", 32'(lzero), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
